// File: rtl/core_proxy_mt_pkg.sv
// Shared CPU definitions for the multi-hart core proxy: state encoding,
// architectural context, bus request formats and reset constants.
package core_proxy_mt_pkg;

  localparam int MAX_HARTS = 8;
  localparam int NUM_REGS  = 4;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_COMMIT  = 4'd3,
    S_UNKNOWN = 4'd4
  } cpu_state_t;

  localparam cpu_state_t LAST_CPU_STATE = S_UNKNOWN;

  typedef logic [1:0] reg_id_t;
  localparam reg_id_t R0 = 2'd0;

  typedef struct packed {
    cpu_state_t                  state;
    logic [31:0]                 pc;
    logic [NUM_REGS-1:0][31:0]   r;
    reg_id_t                     target_id;
    logic [31:0]                 args;
  } context_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  localparam logic [31:0] ARGS_RESET = 32'h0;

  localparam context_t CONTEXT_RESET = '{
    state:     S_FETCH,
    pc:        32'h8000_0000,
    r:         '0,
    target_id: R0,
    args:      ARGS_RESET
  };

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_proxy_mt_hart_rr_arbiter.sv
// Round-robin scan over a hart request mask. Starting just after the
// current index and wrapping (the current index is visited last), picks
// the first requester when advance is high; otherwise holds the current one.
module hart_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] cur,
  input  logic          advance,
  output logic [IW-1:0] next,
  output logic          any_valid
);

  // Wrapping first-match scan starting after the current index.
  always_comb begin
    logic          found;
    int            idx;
    logic [IW-1:0] idx_sel;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    next      = cur;
    found     = 1'b0;
    idx       = 0;
    idx_sel   = '0;
    any_valid = |req;
    for (int k = 1; k <= N; k++) begin
      idx     = (int'(cur) + k) % N;
      idx_sel = IW'(idx);
      if (advance && !found && req[idx_sel]) begin
        next  = idx_sel;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_proxy_mt.sv
// Multi-hart core proxy: keeps one context and one checkpoint per hart,
// steps the active hart through the per-state next-context table, rotates
// harts round-robin at commit/trap boundaries and records traps as sticky
// per-hart errors.
module core_proxy_mt
  import core_proxy_mt_pkg::*;
#(
  parameter int NUM_HARTS  = 2,
  parameter int NUM_STATES = int'(LAST_CPU_STATE) + 1,
  parameter int CNT_W      = 32,
  localparam int HW        = idx_w(NUM_HARTS)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  context_t  [NUM_STATES-1:0]  out_ctx,
  input  ibus_req_t [NUM_STATES-1:0]  out_ireq,
  input  dbus_req_t [NUM_STATES-1:0]  out_dreq,
  input  logic      [NUM_HARTS-1:0]   hart_en,
  input  logic                        rb_valid,
  input  logic      [HW-1:0]          rb_hart,
  output context_t                    ctx,
  output context_t                    ctx0,
  output logic      [HW-1:0]          active_hart,
  output ibus_req_t                   ireq,
  output dbus_req_t                   dreq,
  output logic                        commit_valid,
  output logic      [CNT_W-1:0]       commit_cnt,
  output logic      [NUM_HARTS-1:0]   err,
  output logic      [31:0]            err_pc,
  output logic                        halted
);

  localparam int SW = idx_w(NUM_STATES);

  context_t           ctx_q  [NUM_HARTS];
  context_t           ctx0_q [NUM_HARTS];
  logic [CNT_W-1:0]   cnt_q  [NUM_HARTS];

  context_t           cur;
  context_t           new_ctx;
  logic [SW-1:0]      sidx;
  logic               err_act;
  logic               rb_act;
  logic               trapping;
  logic               advance;
  logic [NUM_HARTS-1:0] err_next;
  logic [HW-1:0]      arb_next;
  logic               arb_any;

  assign cur        = ctx_q[active_hart];
  assign ctx        = cur;
  assign ctx0       = ctx0_q[active_hart];
  assign commit_cnt = cnt_q[active_hart];
  assign sidx       = SW'(cur.state);

  assign err_act      = err[active_hart];
  assign rb_act       = rb_valid && (rb_hart == active_hart);
  assign halted       = ((hart_en & ~err) == '0);
  assign commit_valid = (cur.state == S_COMMIT) && !err_act && !rb_act;
  assign trapping     = !rb_act && (cur.state == S_UNKNOWN);
  assign advance      = commit_valid || err_act || trapping;

  // Select bus requests and the next context for the active hart.
  always_comb begin
    ireq    = out_ireq[sidx];
    dreq    = out_dreq[sidx];
    if (err_act || halted) begin
      ireq = '0;
      dreq = '0;
    end
    new_ctx      = out_ctx[sidx];
    new_ctx.r[0] = '0;
    if (new_ctx.state > LAST_CPU_STATE) new_ctx.state = S_UNKNOWN;
    if (cur.state == S_COMMIT) new_ctx.args = ARGS_RESET;
    new_ctx.target_id = R0;
  end

  // Error flags as they will be after this edge; feeds hart eligibility.
  always_comb begin
    err_next = err;
    if (rb_valid) err_next[rb_hart] = 1'b0;
    if (trapping) err_next[active_hart] = 1'b1;
  end

  hart_rr_arbiter #(
    .N  (NUM_HARTS),
    .IW (HW)
  ) u_arb (
    .req       (hart_en & ~err_next),
    .cur       (active_hart),
    .advance   (advance),
    .next      (arb_next),
    .any_valid (arb_any)
  );

  // Rollback, trap capture, context advance, checkpoint and scheduling.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the per-hart arrays are reset explicitly because every hart must start from CONTEXT_RESET.
      for (int h = 0; h < NUM_HARTS; h++) begin
        ctx_q[h]  <= CONTEXT_RESET;
        ctx0_q[h] <= CONTEXT_RESET;
        cnt_q[h]  <= '0;
      end
      err         <= '0;
      err_pc      <= '0;
      active_hart <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every read above seeing pre-edge state.
      err <= err_next;
      if (trapping) err_pc <= cur.pc;
      if (rb_valid) ctx_q[rb_hart] <= ctx0_q[rb_hart];
      if (!rb_act && !trapping && !err_act) begin
        ctx_q[active_hart] <= new_ctx;
        if (commit_valid) begin
          ctx0_q[active_hart] <= new_ctx;
          cnt_q[active_hart]  <= cnt_q[active_hart] + CNT_W'(1);
        end
      end
      if (arb_any) active_hart <= arb_next;
    end
  end

endmodule

// File: tb/tb_core_proxy_mt.sv
// Directed bench for core_proxy_mt with two harts and a fixed
// FETCH->DECODE->EXEC->COMMIT->FETCH next-context table.
module tb_core_proxy_mt;
  import core_proxy_mt_pkg::*;

  localparam int NH = 2;
  localparam int NS = int'(LAST_CPU_STATE) + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  context_t  [NS-1:0] out_ctx;
  ibus_req_t [NS-1:0] out_ireq;
  dbus_req_t [NS-1:0] out_dreq;
  logic [NH-1:0] hart_en;
  logic          rb_valid;
  logic [0:0]    rb_hart;
  context_t      ctx, ctx0;
  logic [0:0]    active_hart;
  ibus_req_t     ireq;
  dbus_req_t     dreq;
  logic          commit_valid;
  logic [31:0]   commit_cnt;
  logic [NH-1:0] err;
  logic [31:0]   err_pc;
  logic          halted;

  int checks = 0;
  int errors = 0;

  // Context the default table produces out of a commit: FETCH at 0x100C, r1=4, args cleared.
  context_t ckpt;

  core_proxy_mt #(.NUM_HARTS(NH), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .out_ctx(out_ctx), .out_ireq(out_ireq),
    .out_dreq(out_dreq), .hart_en(hart_en), .rb_valid(rb_valid), .rb_hart(rb_hart),
    .ctx(ctx), .ctx0(ctx0), .active_hart(active_hart), .ireq(ireq), .dreq(dreq),
    .commit_valid(commit_valid), .commit_cnt(commit_cnt), .err(err),
    .err_pc(err_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic cpu_state_t nxt(input cpu_state_t s);
    case (s)
      S_FETCH:  return S_DECODE;
      S_DECODE: return S_EXEC;
      S_EXEC:   return S_COMMIT;
      S_COMMIT: return S_FETCH;
      default:  return S_UNKNOWN;
    endcase
  endfunction

  task automatic load_table();
    for (int s = 0; s < NS; s++) begin
      out_ctx[s]           = '0;
      out_ctx[s].state     = nxt(cpu_state_t'(s));
      out_ctx[s].pc        = 32'h1000 + 32'(4 * s);
      out_ctx[s].r[1]      = 32'(s + 1);
      out_ctx[s].target_id = 2'd3;
      out_ctx[s].args      = 32'hA0 + 32'(s);
      out_ireq[s]          = '{valid: 1'b1, addr: 32'h2000 + 32'(s)};
      out_dreq[s]          = '{valid: 1'b1, write: 1'b0, addr: 32'h3000 + 32'(s), wdata: 32'(s)};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ibus_req_t exp_ireq;
    exp_ireq = '{valid: 1'b1, addr: 32'h2000};
    checks++; if (ctx !== CONTEXT_RESET) begin errors++; $display("FAIL reset_ctx: got %h expected %h", ctx, CONTEXT_RESET); end
    checks++; if (ctx0 !== CONTEXT_RESET) begin errors++; $display("FAIL reset_ctx0: got %h expected %h", ctx0, CONTEXT_RESET); end
    checks++; if (active_hart !== 1'b0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_hart); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (ireq !== exp_ireq) begin errors++; $display("FAIL reset_ireq: got %h expected %h", ireq, exp_ireq); end
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", commit_cnt); end
  endtask

  task automatic test_round_robin();
    repeat (3) tick();
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rr_commit0: got %b expected 1", commit_valid); end
    tick();
    checks++; if (active_hart !== 1'b1) begin errors++; $display("FAIL rr_switch1: got %0d expected 1", active_hart); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rr_commit_pulse: got %b expected 0", commit_valid); end
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL rr_cnt1: got %0d expected 0", commit_cnt); end
    checks++; if (ctx !== CONTEXT_RESET) begin errors++; $display("FAIL rr_hart1_ctx: got %h expected %h", ctx, CONTEXT_RESET); end
    repeat (3) tick();
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rr_commit1: got %b expected 1", commit_valid); end
    tick();
    checks++; if (active_hart !== 1'b0) begin errors++; $display("FAIL rr_switch0: got %0d expected 0", active_hart); end
    checks++; if (commit_cnt !== 32'd1) begin errors++; $display("FAIL rr_cnt0: got %0d expected 1", commit_cnt); end
    checks++; if (ctx !== ckpt) begin errors++; $display("FAIL rr_ctx0_after: got %h expected %h", ctx, ckpt); end
    checks++; if (ctx0 !== ckpt) begin errors++; $display("FAIL rr_ckpt0: got %h expected %h", ctx0, ckpt); end
  endtask

  task automatic test_invalid_state();
    out_ctx[0].state = cpu_state_t'(4'd5);
    out_ctx[0].pc    = 32'h8000_0010;
    tick();
    checks++; if (ctx.state !== S_UNKNOWN) begin errors++; $display("FAIL inv_state: got %0d expected %0d", ctx.state, S_UNKNOWN); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL inv_err_early: got %b expected 00", err); end
    tick();
    load_table();
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL inv_err: got %b expected 01", err); end
    checks++; if (err_pc !== 32'h8000_0010) begin errors++; $display("FAIL inv_err_pc: got %h expected 80000010", err_pc); end
    checks++; if (active_hart !== 1'b1) begin errors++; $display("FAIL inv_switch: got %0d expected 1", active_hart); end
    checks++; if (ctx !== ckpt) begin errors++; $display("FAIL inv_hart1_ctx: got %h expected %h", ctx, ckpt); end
  endtask

  task automatic test_rollback();
    rb_valid = 1'b1;
    rb_hart  = 1'b0;
    tick();
    rb_valid = 1'b0;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL rb_err: got %b expected 00", err); end
    checks++; if (active_hart !== 1'b1) begin errors++; $display("FAIL rb_no_switch: got %0d expected 1", active_hart); end
    checks++; if (ctx.state !== S_DECODE) begin errors++; $display("FAIL rb_hart1_step: got %0d expected %0d", ctx.state, S_DECODE); end
    repeat (2) tick();
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rb_commit1: got %b expected 1", commit_valid); end
    tick();
    checks++; if (active_hart !== 1'b0) begin errors++; $display("FAIL rb_return: got %0d expected 0", active_hart); end
    checks++; if (ctx !== ckpt) begin errors++; $display("FAIL rb_restored: got %h expected %h", ctx, ckpt); end
  endtask

  task automatic test_commit_collision();
    repeat (3) tick();
    out_ctx[3].pc = 32'h5550;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL col_pre: got %b expected 1", commit_valid); end
    rb_valid = 1'b1;
    rb_hart  = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL col_commit: got %b expected 0", commit_valid); end
    tick();
    rb_valid = 1'b0;
    load_table();
    checks++; if (active_hart !== 1'b0) begin errors++; $display("FAIL col_no_switch: got %0d expected 0", active_hart); end
    checks++; if (ctx !== ckpt) begin errors++; $display("FAIL col_ctx: got %h expected %h", ctx, ckpt); end
    checks++; if (ctx0 !== ckpt) begin errors++; $display("FAIL col_ckpt: got %h expected %h", ctx0, ckpt); end
    checks++; if (commit_cnt !== 32'd1) begin errors++; $display("FAIL col_cnt: got %0d expected 1", commit_cnt); end
  endtask

  task automatic test_halt_r0();
    out_ctx[0].r[0] = 32'hDEAD_BEEF;
    out_ctx[0].r[1] = 32'h1234;
    tick();
    load_table();
    checks++; if (ctx.r[0] !== 32'h0) begin errors++; $display("FAIL r0_zero: got %h expected 0", ctx.r[0]); end
    checks++; if (ctx.r[1] !== 32'h1234) begin errors++; $display("FAIL r1_write: got %h expected 1234", ctx.r[1]); end
    hart_en = 2'b01;
    out_ctx[1].state = cpu_state_t'(4'd5);
    tick();
    load_table();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL halt_err: got %b expected 01", err); end
    checks++; if (err_pc !== 32'h1004) begin errors++; $display("FAIL halt_err_pc: got %h expected 1004", err_pc); end
    checks++; if (active_hart !== 1'b0) begin errors++; $display("FAIL halt_hold: got %0d expected 0", active_hart); end
    checks++; if (ireq !== '0) begin errors++; $display("FAIL halt_ireq: got %h expected 0", ireq); end
    checks++; if (dreq !== '0) begin errors++; $display("FAIL halt_dreq: got %h expected 0", dreq); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL halt_commit: got %b expected 0", commit_valid); end
  endtask

  initial begin
    ckpt       = '0;
    ckpt.state = S_FETCH;
    ckpt.pc    = 32'h100C;
    ckpt.r[1]  = 32'd4;
    hart_en    = 2'b11;
    rb_valid   = 1'b0;
    rb_hart    = 1'b0;
    load_table();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    #1;
    test_reset();
    test_round_robin();
    test_invalid_state();
    test_rollback();
    test_commit_collision();
    test_halt_r0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_proxy_mt.md
Name: core_proxy_mt

Overview:
- Multi-hart successor to the RefCPU core proxy. Holds one architectural context per hart and, each cycle, selects the per-state next-context and bus requests for the active hart.
- Keeps a per-hart checkpoint taken at S_COMMIT and supports rollback to that checkpoint.
- Rotates among enabled harts round-robin at commit boundaries.
- Reports an internal trap (S_UNKNOWN) as a sticky per-hart error instead of stopping simulation.

Parameters:
- NUM_HARTS, 2, number of hardware contexts (1..8).
- NUM_STATES, LAST_CPU_STATE+1, number of per-state input slices.
- CNT_W, 32, width of the per-hart commit counters.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- out_ctx  in  NUM_STATES x $bits(context_t)  next-context candidate per state
- out_ireq  in  NUM_STATES x $bits(ibus_req_t)  instruction request per state
- out_dreq  in  NUM_STATES x $bits(dbus_req_t)  data request per state
- hart_en  in  NUM_HARTS  scheduling enable mask
- rb_valid  in  1  rollback request
- rb_hart  in  HW=$clog2(NUM_HARTS) (min 1)  hart to roll back
- ctx  out  context_t  active hart's context
- ctx0  out  context_t  active hart's checkpoint
- active_hart  out  HW  active hart index
- ireq  out  ibus_req_t  active hart's instruction request
- dreq  out  dbus_req_t  active hart's data request
- commit_valid  out  1  active hart commits this cycle
- commit_cnt  out  CNT_W  commit count of the active hart
- err  out  NUM_HARTS  sticky per-hart trap flags
- err_pc  out  32  pc of the most recent trap
- halted  out  1  (hart_en & ~err) == 0

Behaviour:
- Reset is synchronous and active-low on resetn; clock is clk. At reset:
  - every ctx[h] and ctx0[h] = CONTEXT_RESET
  - active_hart = 0
  - err = 0, err_pc = 0
  - all commit counters = 0
- Combinational outputs:
  - ireq = out_ireq[ctx.state] and dreq = out_dreq[ctx.state], where ctx = ctx[active_hart].
  - Force ireq and dreq to '0 when err[active_hart] is set or halted is high.
  - commit_valid = (ctx.state == S_COMMIT) && !err[active_hart] && !(rb_valid && rb_hart == active_hart).
- new_ctx, computed for the active hart only:
  - new_ctx = out_ctx[ctx.state], with r[0] = 0.
  - If state > LAST_CPU_STATE, state = S_UNKNOWN.
  - If the current state is S_COMMIT, args = ARGS_RESET.
- Per-cycle update, in priority order:
  1. Rollback (rb_valid): ctx[rb_hart] <= ctx0[rb_hart] and err[rb_hart] <= 0. Applies to any hart, active or not. If rb_hart is the active hart, nothing else happens to it this cycle: no commit, no checkpoint, no counter increment.
  2. Trap: active hart not rolled back and ctx.state == S_UNKNOWN. Set err[active_hart], set err_pc <= ctx.pc, and leave ctx unchanged (frozen).
  3. Normal: ctx[active_hart] <= new_ctx with target_id forced to R0.
     - On commit_valid: ctx0[active_hart] <= new_ctx (target_id = R0), and increment that hart's counter; the counter wraps at 2^CNT_W.
- Inactive harts hold their ctx, ctx0 and counter, except when rolled back.
- Scheduling, evaluated on the same edge, is a switch event when either:
  - commit_valid is high, or
  - the active hart is trapped (err set or trapping this cycle).
- On a switch event, active_hart <= the first h scanning active+1, active+2, … (wrapping) with hart_en[h] && !err_next[h]. The scan may come back to the current hart.
- If no hart is eligible, active_hart holds.
- Clearing hart_en for the active hart mid-instruction does not preempt it; the switch happens at its next commit.
- A rollback that makes a hart eligible again takes effect at the next switch event.
- ctx0, ctx and commit_cnt always reflect active_hart combinationally, i.e. the post-edge value.

Decomposition:
- Shared package (refcpu defs) holds:
  - context_t, ibus_req_t, dbus_req_t
  - the state enum, LAST_CPU_STATE, S_COMMIT, S_UNKNOWN
  - CONTEXT_RESET, ARGS_RESET, R0
- New package constant: MAX_HARTS = 8.
- One sub-module, hart_rr_arbiter: NUM_HARTS request mask, current index and advance strobe in; next index and any_valid out. This is a pure round-robin scan reused by later multithreaded blocks.

Test Plan:
- Reset: after resetn is released, ctx == CONTEXT_RESET, active_hart = 0, err = 0, halted = 0 with hart_en = 2'b11, and ireq = out_ireq[initial state].
- Round-robin: with hart_en = 2'b11, drive hart 0 to S_COMMIT.
  - Expect commit_valid = 1 for one cycle, then active_hart = 1 and commit_cnt = 0.
  - On hart 1's commit, expect active_hart = 0 and commit_cnt = 1.
- Invalid state: out_ctx returns state = LAST_CPU_STATE+1 with pc 0x80000010.
  - Next cycle the state is S_UNKNOWN; the cycle after, err = 2'b01 and err_pc = 0x80000010.
  - active_hart moves to 1 and hart 0's ctx stays frozen.
- Rollback: after hart 0 traps, pulse rb_valid with rb_hart = 0.
  - err[0] clears and ctx[0] equals its last checkpoint.
  - On hart 1's next commit, active_hart returns to 0.
- Commit collision: rb_valid targets the active hart in the same cycle it is in S_COMMIT.
  - commit_valid = 0, ctx0 unchanged, counter unchanged, no hart switch.
- Halt and r0: with hart_en = 2'b01, trap hart 0; expect halted = 1 and ireq = dreq = 0.
  - Separately, out_ctx writes r[0] = 0xDEADBEEF; ctx.r[0] must read 0.
